instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Write-side front end for the processor's serial-fill instruction memory.
- Accepts a program byte stream from a host over a valid/ready handshake.
- Clears the memory, then drives its write enable and data one byte per accepted transfer, so bytes land at addresses 0,1,2,…
- Holds the CPU while a load is in progress, and reports byte count, completion and truncation.

Parameters:
- MEM_DEPTH, 32: number of writable instruction bytes; the load is capped here.
- DATA_W, 8: instruction byte width.
- CNT_W, 6: width of load_count; must hold MEM_DEPTH.

Ports:
- clka  in  1  single clock; all loader state changes on posedge.
- restart  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load session; ignored unless state is IDLE or DONE.
- byte_valid  in  1  host byte valid.
- byte_in  in  DATA_W  host byte.
- byte_last  in  1  qualifies byte_in as the final program byte.
- byte_ready  out  1  loader can accept a byte this cycle.
- mem_restart  out  1  clear strobe to the instruction memory.
- inst_en  out  1  memory write enable.
- instruction_in  out  DATA_W  memory write data.
- load_count  out  CNT_W  bytes written in the current or last session.
- busy  out  1  high in CLEAR and LOAD.
- done  out  1  sticky until the next start.
- truncated  out  1  MEM_DEPTH bytes accepted without byte_last; sticky until the next start.
- cpu_hold  out  1  holds the processor reset while loading.

Behaviour:
- All outputs are registered on posedge clka.
- The memory samples on negedge clka, so outputs are stable for half a cycle before the memory samples them.
- Reset values (asynchronous, while restart is high):
  - state=IDLE.
  - mem_restart=1, so the memory clears while reset is held.
  - cpu_hold=1.
  - inst_en=0, instruction_in=0, byte_ready=0, load_count=0.
  - busy=0, done=0, truncated=0.
- First posedge after reset release: mem_restart=0 and cpu_hold=0 (IDLE values).
- FSM states: IDLE, CLEAR, LOAD, DONE.
- IDLE / DONE:
  - byte_ready=0, cpu_hold=0, inst_en=0.
  - start=1 → CLEAR; same edge sets load_count=0, done=0, truncated=0.
- CLEAR:
  - Lasts exactly one cycle, with mem_restart=1 and cpu_hold=1.
  - The memory clears its contents and its write counter at that cycle's negedge.
  - Then → LOAD.
- LOAD:
  - byte_ready=1 while load_count<MEM_DEPTH.
  - Accept = byte_valid & byte_ready, sampled at posedge k.
  - At posedge k: instruction_in<=byte_in, inst_en<=1, load_count<=load_count+1.
  - The memory writes at the negedge of cycle k.
  - inst_en drops at posedge k+1 unless another accept occurs there; this gives 1 byte/cycle back-to-back throughput.
  - A host holding byte_valid with byte_ready=0 keeps its byte; it is not consumed.
- Leaving LOAD (first match wins):
  - byte_last accepted → DONE; done=1, byte_ready=0 from the next cycle.
  - The MEM_DEPTH-th byte accepted without byte_last → DONE; done=1, truncated=1.
  - Further host bytes are refused (byte_ready=0).
- The final write's inst_en pulse is still emitted on the transition edge into DONE.
- start while in CLEAR or LOAD: ignored.
- start in DONE: a new session; the memory is cleared again.
- byte_last with byte_valid=0: ignored.
- byte_valid outside LOAD: ignored.
- restart mid-load: asynchronous abort.
  - Outputs go to reset values immediately.
  - Any partially loaded memory content is cleared by mem_restart=1 at the following negedges.
- load_count never exceeds MEM_DEPTH and never wraps.

Decomposition:
- Shared package (loader_pkg):
  - State enum (IDLE, CLEAR, LOAD, DONE).
  - Constants MEM_DEPTH, DATA_W and CNT_W, shared with the instruction memory.
- No sub-module: a single FSM plus counter and data register.

Test Plan:
- Reset 3 cycles, release → mem_restart=1 during reset and 0 one cycle after release; cpu_hold 1→0; all other outputs 0.
- start, then bytes A9,01,8D,00,02 back-to-back with last on 02 → CLEAR for 1 cycle; 5 single-cycle inst_en pulses, each with instruction_in matching the byte; memory addresses 0–4 read A9,01,8D,00,02; load_count=5, done=1, cpu_hold=0.
- Host toggles byte_valid every other cycle across 4 bytes → inst_en pulses only on accept cycles; no duplicates; load_count=4.
- 33 bytes with no byte_last → 32 accepted; byte_ready=0 after the 32nd; truncated=1, done=1, load_count=32; the 33rd byte is never written.
- restart asserted after 3 of 6 bytes → outputs reset asynchronously within the same cycle; a subsequent start plus 2-byte load gives load_count=2 and addresses 0–1 hold the new bytes, 2–31 hold 00.
- start pulsed during LOAD, and byte_valid driven in IDLE → no state change and no inst_en activity.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared constants and state type for the instruction loader.
// Sizes match the serial-fill instruction memory.
package loader_pkg;

    localparam int MEM_DEPTH = 32;
    localparam int DATA_W    = 8;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        LOAD,
        DONE
    } state_t;

endpackage

// File: rtl/instr_loader.sv
// Write-side front end for the serial-fill instruction memory.
// Clears memory, streams host bytes into it, holds the CPU meanwhile.
module instr_loader
    import loader_pkg::*;
(
    input  logic              clka,
    input  logic              restart,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [DATA_W-1:0] byte_in,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              mem_restart,
    output logic              inst_en,
    output logic [DATA_W-1:0] instruction_in,
    output logic [CNT_W-1:0]  load_count,
    output logic              busy,
    output logic              done,
    output logic              truncated,
    output logic              cpu_hold
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(MEM_DEPTH);

    state_t            state;
    state_t            state_n;
    logic              accept;
    logic              ready_n;
    logic              mem_restart_n;
    logic              inst_en_n;
    logic [DATA_W-1:0] instr_n;
    logic [CNT_W-1:0]  cnt_n;
    logic              busy_n;
    logic              done_n;
    logic              trunc_n;
    logic              hold_n;

    // Next state and next registered output values.
    always_comb begin
        state_n       = state;
        accept        = byte_valid & byte_ready;
        ready_n       = 1'b0;
        mem_restart_n = 1'b0;
        inst_en_n     = 1'b0;
        instr_n       = instruction_in;
        cnt_n         = load_count;
        busy_n        = 1'b0;
        done_n        = done;
        trunc_n       = truncated;
        hold_n        = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n       = CLEAR;
                    mem_restart_n = 1'b1;
                    hold_n        = 1'b1;
                    busy_n        = 1'b1;
                    cnt_n         = '0;
                    done_n        = 1'b0;
                    trunc_n       = 1'b0;
                end
            end
            CLEAR: begin
                state_n = LOAD;
                hold_n  = 1'b1;
                busy_n  = 1'b1;
                ready_n = 1'b1;
            end
            LOAD: begin
                hold_n  = 1'b1;
                busy_n  = 1'b1;
                ready_n = byte_ready;
                if (accept) begin
                    inst_en_n = 1'b1;
                    instr_n   = byte_in;
                    cnt_n     = load_count + 1'b1;
                    if (byte_last) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else if (cnt_n == DEPTH_C) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        trunc_n = 1'b1;
                    end
                end
                // Final write pulse still goes out on the edge into DONE.
                if (state_n == DONE) begin
                    hold_n  = 1'b0;
                    busy_n  = 1'b0;
                    ready_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset keeps memory cleared, CPU held.
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            state          <= IDLE;
            byte_ready     <= 1'b0;
            mem_restart    <= 1'b1;
            inst_en        <= 1'b0;
            instruction_in <= '0;
            load_count     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            truncated      <= 1'b0;
            cpu_hold       <= 1'b1;
        end else begin
            state          <= state_n;
            byte_ready     <= ready_n;
            mem_restart    <= mem_restart_n;
            inst_en        <= inst_en_n;
            instruction_in <= instr_n;
            load_count     <= cnt_n;
            busy           <= busy_n;
            done           <= done_n;
            truncated      <= trunc_n;
            cpu_hold       <= hold_n;
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: table sessions plus random
// sessions against a byte-stream reference model and memory model.
module tb_instr_loader;
    import loader_pkg::*;

    logic              clka = 1'b0;
    logic              restart = 1'b0;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [DATA_W-1:0] byte_in = '0;
    logic              byte_last = 1'b0;
    logic              byte_ready;
    logic              mem_restart;
    logic              inst_en;
    logic [DATA_W-1:0] instruction_in;
    logic [CNT_W-1:0]  load_count;
    logic              busy;
    logic              done;
    logic              truncated;
    logic              cpu_hold;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int                   mode;
        int                   n;
        bit                   use_last;
        int                   abort_at;
        logic [39:0][7:0]     b;
        int                   exp_cnt;
        bit                   exp_trunc;
    } vec_t;

    vec_t tbl[5];

    logic [7:0] mem[MEM_DEPTH];
    int         wptr = 0;
    logic [7:0] wr_log[$];

    instr_loader dut (
        .clka           (clka),
        .restart        (restart),
        .start          (start),
        .byte_valid     (byte_valid),
        .byte_in        (byte_in),
        .byte_last      (byte_last),
        .byte_ready     (byte_ready),
        .mem_restart    (mem_restart),
        .inst_en        (inst_en),
        .instruction_in (instruction_in),
        .load_count     (load_count),
        .busy           (busy),
        .done           (done),
        .truncated      (truncated),
        .cpu_hold       (cpu_hold)
    );

    always #5 clka = ~clka;

    // Serial-fill memory: samples on negedge, clear resets write pointer.
    always @(negedge clka) begin
        if (mem_restart) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 8'h00;
            wptr = 0;
        end else if (inst_en) begin
            if (wptr < MEM_DEPTH) mem[wptr] = instruction_in;
            wptr++;
            wr_log.push_back(instruction_in);
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    // Reference: bytes landed and truncation from the host stream alone.
    task automatic model(inout vec_t v);
        v.exp_cnt   = (v.n < MEM_DEPTH) ? v.n : MEM_DEPTH;
        v.exp_trunc = !(v.use_last && v.n <= MEM_DEPTH);
    endtask

    task automatic check_mem(input vec_t v, input int cnt);
        int nbad;
        logic [7:0] e;
        nbad = 0;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            e = (i < cnt) ? v.b[i] : 8'h00;
            if (mem[i] !== e) nbad++;
        end
        chk("mem_content", nbad, 0);
    endtask

    task automatic run_session(input vec_t v);
        int  acc;
        int  cyc;
        int  nbad;
        bit  fin;
        bit  acc_now;
        bit  last_now;
        bit  aborted;
        wr_log.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("clear_busy", busy, 1);
        chk("clear_mrst", mem_restart, 1);
        chk("clear_hold", cpu_hold, 1);
        chk("clear_cnt", load_count, 0);
        chk("clear_done", done, 0);
        tick();
        chk("load_ready", byte_ready, 1);
        chk("load_mrst", mem_restart, 0);
        acc = 0;
        cyc = 0;
        fin = 1'b0;
        aborted = 1'b0;
        while (!fin && !aborted && cyc < 300) begin
            case (v.mode)
                0: acc_now = 1'b1;
                1: acc_now = (cyc % 2) == 0;
                default: acc_now = $urandom_range(0, 2) != 0;
            endcase
            if (acc >= v.n) acc_now = 1'b0;
            byte_valid = acc_now;
            byte_in    = acc_now ? v.b[acc] : 8'($urandom);
            last_now   = acc_now && v.use_last && (acc == v.n - 1);
            byte_last  = acc_now ? last_now : 1'($urandom);
            start      = (v.mode == 2) && ($urandom_range(0, 5) == 0);
            tick();
            start = 1'b0;
            if (acc_now) begin
                acc++;
                fin = last_now || (acc == MEM_DEPTH);
            end
            chk("inst_en", inst_en, acc_now);
            if (acc_now) chk("instr_data", instruction_in, v.b[acc-1]);
            chk("count", load_count, acc);
            chk("done", done, fin);
            chk("ready", byte_ready, !fin);
            chk("busy", busy, !fin);
            chk("hold", cpu_hold, !fin);
            if (v.abort_at != 0 && acc == v.abort_at) aborted = 1'b1;
            cyc++;
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        if (aborted) begin
            restart = 1'b1;
            #1;
            chk("abort_mrst", mem_restart, 1);
            chk("abort_hold", cpu_hold, 1);
            chk("abort_en", inst_en, 0);
            chk("abort_cnt", load_count, 0);
            chk("abort_busy", busy, 0);
            chk("abort_ready", byte_ready, 0);
            tick();
            tick();
            restart = 1'b0;
            tick();
            chk("abort_rel_mrst", mem_restart, 0);
            check_mem(v, 0);
            return;
        end
        if (!fin) chk("session_timeout", 0, 1);
        // Host keeps offering a byte after completion; must be refused.
        byte_valid = 1'b1;
        byte_in    = (acc < v.n) ? v.b[acc] : 8'h5A;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("post_en", inst_en, 0);
            chk("post_cnt", load_count, v.exp_cnt);
        end
        byte_valid = 1'b0;
        chk("final_done", done, 1);
        chk("final_trunc", truncated, v.exp_trunc);
        chk("final_hold", cpu_hold, 0);
        chk("wr_count", wr_log.size(), v.exp_cnt);
        nbad = 0;
        for (int i = 0; i < wr_log.size() && i < 40; i++)
            if (wr_log[i] !== v.b[i]) nbad++;
        chk("wr_log", nbad, 0);
        check_mem(v, v.exp_cnt);
    endtask

    initial begin
        vec_t rv;
        // Session table: mode, n, last, abort, bytes, expected.
        for (int t = 0; t < 5; t++)
            for (int i = 0; i < 40; i++) tbl[t].b[i] = 8'($urandom);
        tbl[0].mode = 0; tbl[0].n = 5; tbl[0].use_last = 1;
        tbl[0].abort_at = 0; tbl[0].exp_cnt = 5; tbl[0].exp_trunc = 0;
        tbl[0].b[0] = 8'hA9; tbl[0].b[1] = 8'h01; tbl[0].b[2] = 8'h8D;
        tbl[0].b[3] = 8'h00; tbl[0].b[4] = 8'h02;
        tbl[1].mode = 1; tbl[1].n = 4; tbl[1].use_last = 1;
        tbl[1].abort_at = 0; tbl[1].exp_cnt = 4; tbl[1].exp_trunc = 0;
        tbl[2].mode = 0; tbl[2].n = 33; tbl[2].use_last = 0;
        tbl[2].abort_at = 0; tbl[2].exp_cnt = 32; tbl[2].exp_trunc = 1;
        tbl[3].mode = 0; tbl[3].n = 6; tbl[3].use_last = 1;
        tbl[3].abort_at = 3; tbl[3].exp_cnt = 0; tbl[3].exp_trunc = 0;
        tbl[4].mode = 0; tbl[4].n = 2; tbl[4].use_last = 1;
        tbl[4].abort_at = 0; tbl[4].exp_cnt = 2; tbl[4].exp_trunc = 0;

        #2 restart = 1'b1;
        #1;
        chk("rst_mrst", mem_restart, 1);
        chk("rst_hold", cpu_hold, 1);
        tick();
        tick();
        tick();
        chk("rst_en", inst_en, 0);
        chk("rst_data", instruction_in, 0);
        chk("rst_ready", byte_ready, 0);
        chk("rst_cnt", load_count, 0);
        chk("rst_flags", {busy, done, truncated}, 0);
        restart = 1'b0;
        tick();
        chk("rel_mrst", mem_restart, 0);
        chk("rel_hold", cpu_hold, 0);

        // Host bytes in IDLE are ignored.
        byte_valid = 1'b1;
        byte_last  = 1'b1;
        byte_in    = 8'h77;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_en", inst_en, 0);
            chk("idle_state", {byte_ready, busy, load_count}, 0);
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        tick();

        for (int t = 0; t < 5; t++) run_session(tbl[t]);

        for (int r = 0; r < 8; r++) begin
            rv.mode     = 2;
            rv.n        = $urandom_range(1, 40);
            rv.use_last = 1'($urandom_range(0, 1));
            rv.abort_at = 0;
            if (!rv.use_last && rv.n < MEM_DEPTH)
                rv.n = MEM_DEPTH + $urandom_range(0, 8);
            for (int i = 0; i < 40; i++) rv.b[i] = 8'($urandom);
            model(rv);
            run_session(rv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
